// File: rtl/chip_rom_uart_dumper_if.sv
// ROM bus between the dumper (master: drives address) and the chip-ID ROM
// (slave: returns the byte combinationally in the same cycle).
interface chip_rom_uart_dumper_if;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/chip_rom_uart_dumper.sv
// Walks the chip-ID ROM from address 0 to LAST_ADDR and sends every byte out
// as an 8N1 UART frame. One FETCH cycle per byte captures the ROM data and
// doubles as a one-clock extension of the stop bit.
module chip_rom_uart_dumper #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned LAST_ADDR    = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          start,
  chip_rom_uart_dumper_if.master        rom,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned     CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]      LastAddr = 8'(LAST_ADDR);

  typedef enum logic [2:0] {StIdle, StFetch, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic [7:0]      addr_q;
  logic            tx_q;
  logic            busy_q;
  logic            done_q;
  logic            bit_end;

  // Last clock of the current bit period.
  assign bit_end = (baud_q == CntMax);

  assign rom.rom_addr = addr_q;
  assign uart_tx      = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;

  // Sequencer FSM with registered outputs; baud counter restarts on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != StIdle && !ena) begin
        // Abort: truncate any partial frame, no done pulse.
        state_q <= StIdle;
        baud_q  <= '0;
        bit_q   <= '0;
        addr_q  <= '0;
        tx_q    <= 1'b1;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            if (ena && start) begin
              addr_q  <= '0;
              busy_q  <= 1'b1;
              baud_q  <= '0;
              state_q <= StFetch;
            end
          end
          StFetch: begin
            shift_q <= rom.rom_data;
            tx_q    <= 1'b0;
            baud_q  <= '0;
            state_q <= StStart;
          end
          StStart: begin
            if (bit_end) begin
              baud_q  <= '0;
              bit_q   <= '0;
              tx_q    <= shift_q[0];
              state_q <= StData;
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          StData: begin
            if (bit_end) begin
              baud_q <= '0;
              if (bit_q == 3'd7) begin
                tx_q    <= 1'b1;
                state_q <= StStop;
              end else begin
                bit_q   <= bit_q + 3'd1;
                shift_q <= shift_q >> 1;
                tx_q    <= shift_q[1];
              end
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          StStop: begin
            if (bit_end) begin
              baud_q <= '0;
              if (addr_q == LastAddr) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                addr_q  <= '0;
              end else begin
                addr_q  <= addr_q + 8'd1;
                state_q <= StFetch;
              end
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
